level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
- Game-flow controller sitting directly downstream of the per-level blocks (Level1..Level3).
- Consumes the active level's win/lose flags and drives the level select plus an active-low level reset into the level blocks.
- Tracks remaining lives and sequences title → play → win/lose banner → next level / retry / game over / victory.
- Its screen code is read by the renderer to choose which overlay to draw.

Parameters:
- NUM_LEVELS, 3, number of playable levels; level indices run 0..NUM_LEVELS-1 (max 4).
- START_LIVES, 3, lives loaded at game start (1..7).
- LOAD_CYCLES, 4, cycles level_reset_n is held low before play starts (≥2).
- BANNER_CYCLES, 50000000, duration of the win/lose banner in vga_clock cycles (2 s at 25 MHz).

Ports:
- vga_clock, input, 1, system pixel clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- start_button, input, 1, level-sensitive button; only its rising edge is used.
- level_win, input, 1, win flag of the currently selected level.
- level_lose, input, 1, lose flag of the currently selected level.
- level_select, output, 2, index of the active level.
- level_reset_n, output, 1, active-low reset to the level blocks; low = level frozen and reinitialised.
- lives, output, 3, remaining lives.
- screen, output, 3, state code: 0 TITLE, 1 LOAD, 2 PLAY, 3 WON_LEVEL, 4 LOST_LIFE, 5 GAME_OVER, 6 VICTORY.

Behaviour:
- Reset values (reset high at a clock edge): state=TITLE, level_select=0, lives=START_LIVES, level_reset_n=0, timer=0, start_prev=1.
  - start_prev=1 so a button already held through reset does not start the game.
- start_edge = start_button & ~start_prev; start_prev updates every cycle.
- All outputs are registered; screen always equals the current state code.
- level_reset_n=1 only in PLAY; 0 in every other state.
- TITLE: on start_edge → LOAD, timer=0.
- LOAD: timer counts 0..LOAD_CYCLES-1; at timer==LOAD_CYCLES-1 → PLAY, timer=0.
  - LOAD lasts exactly LOAD_CYCLES cycles.
- PLAY: level_win/level_lose are sampled every cycle.
  - win (priority over lose when both are high in the same cycle) → WON_LEVEL, timer=0.
  - lose → LOST_LIFE, lives decremented by 1 in the same edge, timer=0.
  - start_edge is ignored.
- WON_LEVEL: timer counts to BANNER_CYCLES-1, then:
  - if level_select==NUM_LEVELS-1 → VICTORY;
  - else level_select+1 → LOAD.
- LOST_LIFE: timer counts to BANNER_CYCLES-1, then:
  - if lives==0 → GAME_OVER;
  - else → LOAD with level_select unchanged.
- GAME_OVER and VICTORY: hold until start_edge, then lives=START_LIVES, level_select=0 → LOAD.
- Inputs win/lose are ignored outside PLAY, including any stale flags during banners and LOAD.
- lives never underflows: a decrement occurs only in PLAY, and PLAY is unreachable with lives==0.
- timer is 32-bit unsigned, cleared on every state entry, and never wraps.
- Reset asserted mid-operation (any state, any timer value) returns all state to reset values on that edge; the level blocks go to reset the next cycle via level_reset_n=0.

Test Plan (bench uses LOAD_CYCLES=4, BANNER_CYCLES=8):
- Reset with start_button held high, release, then pulse start → screen stays 0 until the pulse; after the pulse, screen=1 for exactly 4 cycles, then screen=2 with level_reset_n=1.
- In PLAY level 0, pulse level_win 1 cycle → screen=3 for 8 cycles with level_reset_n=0, then LOAD with level_select=1, then PLAY.
- In PLAY, assert level_win and level_lose in the same cycle → screen=3, lives unchanged at 3.
- Three level_lose events on level 1 → lives 2, 1, 0; the first two return to LOAD with level_select=1; the third goes to screen=5 after 8 cycles; start pulse → lives=3, level_select=0, screen=1.
- Win levels 0, 1, 2 in sequence → after the third banner screen=6; start pulse → level_select=0, screen=1.
- Assert reset during WON_LEVEL at timer=5 → next cycle screen=0, level_select=0, lives=3, level_reset_n=0; level_win held high while in TITLE/LOAD causes no transition.

Source files
------------

// File: rtl/level_sequencer_if.sv
// Game-flow signals exchanged between the level sequencer and the level blocks.
// The sequencer side drives level select/reset and the overlay code.
interface level_sequencer_if;
   logic       start_button;
   logic       level_win;
   logic       level_lose;
   logic [1:0] level_select;
   logic       level_reset_n;
   logic [2:0] lives;
   logic [2:0] screen;

   modport master (
      input  start_button,
      input  level_win,
      input  level_lose,
      output level_select,
      output level_reset_n,
      output lives,
      output screen
   );

   modport slave (
      output start_button,
      output level_win,
      output level_lose,
      input  level_select,
      input  level_reset_n,
      input  lives,
      input  screen
   );
endinterface

// File: rtl/level_sequencer.sv
// Game-flow controller: title, level load, play, banners, retries, game over
// and victory, driving the level select and active-low level reset.
module level_sequencer #(
   parameter int unsigned NUM_LEVELS    = 3,
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned LOAD_CYCLES   = 4,
   parameter int unsigned BANNER_CYCLES = 50000000
) (
   input  logic              vga_clock,
   input  logic              reset,
   level_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      TITLE     = 3'd0,
      LOAD      = 3'd1,
      PLAY      = 3'd2,
      WON_LEVEL = 3'd3,
      LOST_LIFE = 3'd4,
      GAME_OVER = 3'd5,
      VICTORY   = 3'd6
   } state_e;

   localparam logic [31:0] LOAD_LAST   = 32'(LOAD_CYCLES - 1);
   localparam logic [31:0] BANNER_LAST = 32'(BANNER_CYCLES - 1);
   localparam logic [1:0]  LVL_LAST    = 2'(NUM_LEVELS - 1);
   localparam logic [2:0]  LIVES_INIT  = 3'(START_LIVES);

   state_e      state_q, state_d;
   logic [1:0]  lvl_q, lvl_d;
   logic [2:0]  lives_q, lives_d;
   logic [31:0] timer_q, timer_d;
   logic        start_prev_q;
   logic        rst_n_q, rst_n_d;
   logic        start_edge;

   assign start_edge = bus.start_button & ~start_prev_q;

   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      lives_d = lives_q;
      timer_d = timer_q;
      unique case (state_q)
         TITLE: begin
            if (start_edge) begin
               state_d = LOAD;
               timer_d = '0;
            end
         end
         LOAD: begin
            if (timer_q == LOAD_LAST) begin
               state_d = PLAY;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         PLAY: begin
            // win takes priority when both flags rise together
            if (bus.level_win) begin
               state_d = WON_LEVEL;
               timer_d = '0;
            end else if (bus.level_lose) begin
               state_d = LOST_LIFE;
               lives_d = lives_q - 3'd1;
               timer_d = '0;
            end
         end
         WON_LEVEL: begin
            if (timer_q == BANNER_LAST) begin
               timer_d = '0;
               if (lvl_q == LVL_LAST) begin
                  state_d = VICTORY;
               end else begin
                  state_d = LOAD;
                  lvl_d   = lvl_q + 2'd1;
               end
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         LOST_LIFE: begin
            if (timer_q == BANNER_LAST) begin
               timer_d = '0;
               state_d = (lives_q == 3'd0) ? GAME_OVER : LOAD;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         GAME_OVER, VICTORY: begin
            if (start_edge) begin
               state_d = LOAD;
               lvl_d   = '0;
               lives_d = LIVES_INIT;
               timer_d = '0;
            end
         end
         default: begin
            state_d = TITLE;
            timer_d = '0;
         end
      endcase
      rst_n_d = (state_d == PLAY);
   end

   // start_prev resets high so a button held through reset is not an edge
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         state_q      <= TITLE;
         lvl_q        <= '0;
         lives_q      <= LIVES_INIT;
         timer_q      <= '0;
         start_prev_q <= 1'b1;
         rst_n_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lvl_q        <= lvl_d;
         lives_q      <= lives_d;
         timer_q      <= timer_d;
         start_prev_q <= bus.start_button;
         rst_n_q      <= rst_n_d;
      end
   end

   assign bus.level_select  = lvl_q;
   assign bus.level_reset_n = rst_n_q;
   assign bus.lives         = lives_q;
   assign bus.screen        = state_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: directed per-cycle expectations are
// queued by the driver and compared by an independent monitor.
module tb_level_sequencer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   level_sequencer_if bus();

   level_sequencer #(
      .NUM_LEVELS   (3),
      .START_LIVES  (3),
      .LOAD_CYCLES  (4),
      .BANNER_CYCLES(8)
   ) dut (
      .vga_clock(clk),
      .reset    (rst),
      .bus      (bus)
   );

   typedef struct {
      logic [2:0] scr;
      logic [1:0] lvl;
      logic [2:0] liv;
      logic       rn;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk({e.tag, ".screen"}, 32'(bus.screen), 32'(e.scr));
         chk({e.tag, ".level_select"}, 32'(bus.level_select), 32'(e.lvl));
         chk({e.tag, ".lives"}, 32'(bus.lives), 32'(e.liv));
         chk({e.tag, ".level_reset_n"}, 32'(bus.level_reset_n), 32'(e.rn));
      end
   end

   // drive one cycle of inputs and queue the state expected after the edge
   task automatic cyc(input logic r, input logic sb, input logic w,
                      input logic l, input logic [2:0] s,
                      input logic [1:0] lv, input logic [2:0] li,
                      input string t);
      exp_t e;
      @(negedge clk);
      rst              = r;
      bus.start_button = sb;
      bus.level_win    = w;
      bus.level_lose   = l;
      e.scr = s;
      e.lvl = lv;
      e.liv = li;
      e.rn  = (s == 3'd2);
      e.tag = t;
      q.push_back(e);
   endtask

   task automatic load_to_play(input logic [1:0] lv, input logic [2:0] li);
      repeat (3) cyc(0, 0, 0, 0, 3'd1, lv, li, "load");
      cyc(0, 0, 0, 0, 3'd2, lv, li, "play");
   endtask

   task automatic banner(input logic [2:0] s, input logic [1:0] lv,
                         input logic [2:0] li);
      repeat (7) cyc(0, 0, 0, 0, s, lv, li, "banner");
   endtask

   initial begin
      rst              = 1'b1;
      bus.start_button = 1'b1;
      bus.level_win    = 1'b0;
      bus.level_lose   = 1'b0;

      // reset with button held; held button must not start
      cyc(1, 1, 0, 0, 3'd0, 2'd0, 3'd3, "reset");
      cyc(0, 1, 0, 0, 3'd0, 2'd0, 3'd3, "held");
      cyc(0, 1, 0, 0, 3'd0, 2'd0, 3'd3, "held");
      cyc(0, 0, 0, 0, 3'd0, 2'd0, 3'd3, "release");
      cyc(0, 1, 0, 0, 3'd1, 2'd0, 3'd3, "start");
      load_to_play(2'd0, 3'd3);
      cyc(0, 0, 0, 0, 3'd2, 2'd0, 3'd3, "play0");
      cyc(0, 1, 0, 0, 3'd2, 2'd0, 3'd3, "play_start_ign");

      // win level 0
      cyc(0, 0, 1, 0, 3'd3, 2'd0, 3'd3, "win0");
      banner(3'd3, 2'd0, 3'd3);
      cyc(0, 0, 0, 0, 3'd1, 2'd1, 3'd3, "next1");
      load_to_play(2'd1, 3'd3);

      // three losses on level 1
      cyc(0, 0, 0, 1, 3'd4, 2'd1, 3'd2, "lose1");
      banner(3'd4, 2'd1, 3'd2);
      cyc(0, 0, 0, 0, 3'd1, 2'd1, 3'd2, "retry1");
      load_to_play(2'd1, 3'd2);
      cyc(0, 0, 0, 1, 3'd4, 2'd1, 3'd1, "lose2");
      banner(3'd4, 2'd1, 3'd1);
      cyc(0, 0, 0, 0, 3'd1, 2'd1, 3'd1, "retry2");
      load_to_play(2'd1, 3'd1);
      cyc(0, 0, 0, 1, 3'd4, 2'd1, 3'd0, "lose3");
      banner(3'd4, 2'd1, 3'd0);
      cyc(0, 0, 0, 0, 3'd5, 2'd1, 3'd0, "gameover");
      repeat (3) cyc(0, 0, 1, 1, 3'd5, 2'd1, 3'd0, "go_hold");
      cyc(0, 1, 0, 0, 3'd1, 2'd0, 3'd3, "go_restart");
      load_to_play(2'd0, 3'd3);

      // win+lose together: win wins, lives unchanged
      cyc(0, 0, 1, 1, 3'd3, 2'd0, 3'd3, "winlose");
      banner(3'd3, 2'd0, 3'd3);
      cyc(0, 0, 0, 0, 3'd1, 2'd1, 3'd3, "next1b");
      load_to_play(2'd1, 3'd3);
      cyc(0, 0, 1, 0, 3'd3, 2'd1, 3'd3, "win1");
      banner(3'd3, 2'd1, 3'd3);
      cyc(0, 0, 0, 0, 3'd1, 2'd2, 3'd3, "next2");
      load_to_play(2'd2, 3'd3);
      cyc(0, 0, 1, 0, 3'd3, 2'd2, 3'd3, "win2");
      banner(3'd3, 2'd2, 3'd3);
      cyc(0, 0, 0, 0, 3'd6, 2'd2, 3'd3, "victory");
      repeat (2) cyc(0, 0, 0, 0, 3'd6, 2'd2, 3'd3, "vic_hold");
      cyc(0, 1, 0, 0, 3'd1, 2'd0, 3'd3, "vic_restart");
      load_to_play(2'd0, 3'd3);

      // reset mid-banner at timer 5
      cyc(0, 0, 1, 0, 3'd3, 2'd0, 3'd3, "win0c");
      banner(3'd3, 2'd0, 3'd3);
      cyc(0, 0, 0, 0, 3'd1, 2'd1, 3'd3, "next1c");
      load_to_play(2'd1, 3'd3);
      cyc(0, 0, 1, 0, 3'd3, 2'd1, 3'd3, "win1c");
      repeat (5) cyc(0, 0, 0, 0, 3'd3, 2'd1, 3'd3, "banner_t");
      cyc(1, 0, 1, 0, 3'd0, 2'd0, 3'd3, "mid_reset");

      // stale win in TITLE and LOAD is ignored
      repeat (3) cyc(0, 0, 1, 0, 3'd0, 2'd0, 3'd3, "title_win");
      cyc(0, 1, 1, 0, 3'd1, 2'd0, 3'd3, "start_w");
      repeat (3) cyc(0, 0, 1, 0, 3'd1, 2'd0, 3'd3, "load_win");
      cyc(0, 0, 1, 0, 3'd2, 2'd0, 3'd3, "play_w");
      cyc(0, 0, 1, 0, 3'd3, 2'd0, 3'd3, "win_w");

      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
